// File: rtl/rs_pkg.sv
// rs_pkg: shared sizes and entry record for the ALU reservation-station scheduler
package rs_pkg;
    localparam int ALU  = 5;
    localparam int ROB  = 3;
    localparam int AGEW = 3;
    typedef logic [ROB:0]    rs_tag_t;
    typedef logic [AGEW-1:0] rs_age_t;
    typedef struct packed {
        logic    busy;
        rs_tag_t tag1;
        logic    rdy1;
        rs_tag_t tag2;
        logic    rdy2;
        rs_age_t age;
    } rs_entry_t;
endpackage

// File: rtl/rs_oldest_select.sv
// rs_oldest_select: picks the ready entry with the largest age and reports that age
module rs_oldest_select
    import rs_pkg::*;
(
    input  logic [ALU:0]            ready,
    input  logic [(ALU+1)*AGEW-1:0] ages,
    output logic [ALU:0]            grant,
    output logic [AGEW-1:0]         issued_age
);
    logic found;
    // linear max scan; live ages are distinct so the winner is unique
    always_comb begin
        grant      = '0;
        issued_age = '0;
        found      = 1'b0;
        for (int i = 0; i <= ALU; i++) begin
            if (ready[i] && (!found || ages[i*AGEW +: AGEW] > issued_age)) begin
                grant      = '0;
                grant[i]   = 1'b1;
                issued_age = ages[i*AGEW +: AGEW];
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: tracks ALU station occupancy/readiness and issues the oldest ready entry
module rs_issue_scheduler
    import rs_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [ALU:0] allocRequests,
    input  logic [ROB:0] src1Tag,
    input  logic         src1Ready,
    input  logic [ROB:0] src2Tag,
    input  logic         src2Ready,
    input  logic         cdbValid,
    input  logic [ROB:0] cdbTag,
    input  logic         flush,
    input  logic         issueReady,
    output logic [ALU:0] ALUBusyVector,
    output logic         issueValid,
    output logic [ALU:0] issueGrant
);
    rs_entry_t               ent [ALU:0];
    logic [ALU:0]            busy, ready;
    logic [(ALU+1)*AGEW-1:0] ages;
    rs_age_t                 issued_age;
    logic                    fire, alloc_ok, age_ok;

    // flatten entry state into vectors for selection and output
    always_comb begin
        busy  = '0;
        ready = '0;
        ages  = '0;
        for (int i = 0; i <= ALU; i++) begin
            busy[i]                = ent[i].busy;
            ready[i]               = ent[i].busy & ent[i].rdy1 & ent[i].rdy2;
            ages[i*AGEW +: AGEW]   = ent[i].age;
        end
    end

    assign ALUBusyVector = busy;
    assign issueValid    = |ready;
    assign fire          = issueValid & issueReady;
    assign alloc_ok      = |(allocRequests & ~busy);

    rs_oldest_select u_sel (
        .ready      (ready),
        .ages       (ages),
        .grant      (issueGrant),
        .issued_age (issued_age)
    );

    // entry update: reset > flush > allocate > issue > wakeup/age
    always_ff @(posedge clk) begin
        for (int i = 0; i <= ALU; i++) begin
            if (reset) begin
                ent[i] <= '0;
            end else if (flush) begin
                ent[i].busy <= 1'b0;
                ent[i].age  <= '0;
            end else if (allocRequests[i] && !ent[i].busy) begin
                ent[i].busy <= 1'b1;
                ent[i].tag1 <= src1Tag;
                ent[i].rdy1 <= src1Ready | (cdbValid && cdbTag == src1Tag);
                ent[i].tag2 <= src2Tag;
                ent[i].rdy2 <= src2Ready | (cdbValid && cdbTag == src2Tag);
                ent[i].age  <= '0;
            end else if (ent[i].busy) begin
                if (fire && issueGrant[i]) begin
                    ent[i].busy <= 1'b0;
                end else begin
                    if (cdbValid && ent[i].tag1 == cdbTag) ent[i].rdy1 <= 1'b1;
                    if (cdbValid && ent[i].tag2 == cdbTag) ent[i].rdy2 <= 1'b1;
                    ent[i].age <= ent[i].age + rs_age_t'(alloc_ok)
                                  - rs_age_t'(fire && ent[i].age > issued_age);
                end
            end
        end
    end

    // live ages must be distinct and below the occupancy count
    always_comb begin
        age_ok = 1'b1;
        for (int i = 0; i <= ALU; i++) begin
            if (busy[i]) begin
                if (int'(ent[i].age) >= $countones(busy)) age_ok = 1'b0;
                for (int j = i + 1; j <= ALU; j++)
                    if (busy[j] && ent[j].age == ent[i].age) age_ok = 1'b0;
            end
        end
    end

    a_alloc_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(allocRequests));
    a_alloc_free:   assert property (@(posedge clk) disable iff (reset || flush) (allocRequests & busy) == '0);
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(issueGrant));
    a_grant_busy:   assert property (@(posedge clk) disable iff (reset) (issueGrant & ~busy) == '0);
    a_age_ok:       assert property (@(posedge clk) disable iff (reset) age_ok);
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed scenarios plus a queue-ordered reference model run
module tb_rs_issue_scheduler;
    logic       clk = 0, reset = 1;
    logic [5:0] allocRequests = '0;
    logic [3:0] src1Tag = '0, src2Tag = '0, cdbTag = '0;
    logic       src1Ready = 0, src2Ready = 0, cdbValid = 0, flush = 0, issueReady = 0;
    logic [5:0] ALUBusyVector, issueGrant;
    logic       issueValid;
    int         checks = 0, errors = 0;

    typedef struct {
        int         idx;
        logic [3:0] t1;
        logic       r1;
        logic [3:0] t2;
        logic       r2;
    } ment_t;
    ment_t mq[$];

    rs_issue_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .allocRequests (allocRequests),
        .src1Tag       (src1Tag),
        .src1Ready     (src1Ready),
        .src2Tag       (src2Tag),
        .src2Ready     (src2Ready),
        .cdbValid      (cdbValid),
        .cdbTag        (cdbTag),
        .flush         (flush),
        .issueReady    (issueReady),
        .ALUBusyVector (ALUBusyVector),
        .issueValid    (issueValid),
        .issueGrant    (issueGrant)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        allocRequests = '0; src1Tag = '0; src1Ready = 0; src2Tag = '0; src2Ready = 0;
        cdbValid = 0; cdbTag = '0; flush = 0; issueReady = 0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic alloc(input int e, input logic [3:0] t1, input logic r1, input logic [3:0] t2, input logic r2);
        allocRequests = 6'(1 << e);
        src1Tag = t1; src1Ready = r1; src2Tag = t2; src2Ready = r2;
    endtask

    task automatic test_reset;
        idle();
        reset = 1;
        tick();
        tick();
        checks++; if (ALUBusyVector !== 6'b0) begin errors++; $display("FAIL reset_busy got %b exp 000000", ALUBusyVector); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", issueValid); end
        checks++; if (issueGrant !== 6'b0) begin errors++; $display("FAIL reset_grant got %b exp 000000", issueGrant); end
        reset = 0;
    endtask

    task automatic test_single_issue;
        do_reset();
        alloc(0, 4'd0, 1, 4'd0, 1);
        issueReady = 1;
        tick();
        allocRequests = '0;
        checks++; if (ALUBusyVector !== 6'b000001) begin errors++; $display("FAIL t1_busy got %b exp 000001", ALUBusyVector); end
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", issueValid); end
        checks++; if (issueGrant !== 6'b000001) begin errors++; $display("FAIL t1_grant got %b exp 000001", issueGrant); end
        tick();
        checks++; if (ALUBusyVector !== 6'b0) begin errors++; $display("FAIL t1_freed got %b exp 000000", ALUBusyVector); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL t1_empty_valid got %b exp 0", issueValid); end
    endtask

    task automatic test_wakeup;
        do_reset();
        alloc(0, 4'd1, 1, 4'd3, 0);
        tick();
        alloc(1, 4'd1, 1, 4'd1, 1);
        tick();
        allocRequests = '0;
        checks++; if (issueGrant !== 6'b000010) begin errors++; $display("FAIL t2_grant_e1 got %b exp 000010", issueGrant); end
        issueReady = 1; cdbValid = 1; cdbTag = 4'd3;
        tick();
        cdbValid = 0;
        checks++; if (issueGrant !== 6'b000001) begin errors++; $display("FAIL t2_grant_e0 got %b exp 000001", issueGrant); end
        checks++; if (ALUBusyVector !== 6'b000001) begin errors++; $display("FAIL t2_busy got %b exp 000001", ALUBusyVector); end
        tick();
        checks++; if (ALUBusyVector !== 6'b0) begin errors++; $display("FAIL t2_drained got %b exp 000000", ALUBusyVector); end
    endtask

    task automatic test_age_order;
        do_reset();
        alloc(0, 4'd0, 1, 4'd0, 1);
        tick();
        alloc(1, 4'd0, 1, 4'd0, 1);
        tick();
        allocRequests = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (issueGrant !== 6'b000001) begin errors++; $display("FAIL t3_hold%0d got %b exp 000001", k, issueGrant); end
            tick();
        end
        issueReady = 1;
        checks++; if (issueGrant !== 6'b000001) begin errors++; $display("FAIL t3_first got %b exp 000001", issueGrant); end
        tick();
        checks++; if (issueGrant !== 6'b000010) begin errors++; $display("FAIL t3_second got %b exp 000010", issueGrant); end
        tick();
        checks++; if (ALUBusyVector !== 6'b0) begin errors++; $display("FAIL t3_empty got %b exp 000000", ALUBusyVector); end
    endtask

    task automatic test_bypass;
        do_reset();
        alloc(2, 4'd5, 0, 4'd0, 1);
        cdbValid = 1; cdbTag = 4'd5;
        tick();
        alloc(3, 4'd6, 0, 4'd0, 1);
        tick();
        idle();
        checks++; if (ALUBusyVector !== 6'b001100) begin errors++; $display("FAIL t4_busy got %b exp 001100", ALUBusyVector); end
        checks++; if (issueGrant !== 6'b000100) begin errors++; $display("FAIL t4_grant got %b exp 000100", issueGrant); end
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL t4_valid got %b exp 1", issueValid); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        alloc(0, 4'd0, 1, 4'd0, 1);
        tick();
        alloc(1, 4'd0, 1, 4'd0, 1);
        tick();
        alloc(2, 4'd0, 1, 4'd0, 1);
        issueReady = 1;
        tick();
        allocRequests = '0;
        checks++; if (ALUBusyVector !== 6'b000110) begin errors++; $display("FAIL t7_busy got %b exp 000110", ALUBusyVector); end
        checks++; if (issueGrant !== 6'b000010) begin errors++; $display("FAIL t7_grant_e1 got %b exp 000010", issueGrant); end
        tick();
        checks++; if (issueGrant !== 6'b000100) begin errors++; $display("FAIL t7_grant_e2 got %b exp 000100", issueGrant); end
        tick();
        idle();
    endtask

    task automatic test_full_flush;
        do_reset();
        for (int e = 0; e < 6; e++) begin
            alloc(e, 4'd1, 0, 4'd2, 0);
            tick();
        end
        allocRequests = '0;
        checks++; if (ALUBusyVector !== 6'b111111) begin errors++; $display("FAIL t5_full got %b exp 111111", ALUBusyVector); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL t5_full_valid got %b exp 0", issueValid); end
        alloc(0, 4'd0, 1, 4'd0, 1);
        flush = 1;
        tick();
        idle();
        checks++; if (ALUBusyVector !== 6'b0) begin errors++; $display("FAIL t5_flushed got %b exp 000000", ALUBusyVector); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL t5_flush_valid got %b exp 0", issueValid); end
        alloc(4, 4'd0, 1, 4'd0, 1);
        tick();
        allocRequests = '0;
        flush = 1;
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL t5_preflush_valid got %b exp 1", issueValid); end
        tick();
        flush = 0;
        checks++; if (ALUBusyVector !== 6'b0) begin errors++; $display("FAIL t5_reflushed got %b exp 000000", ALUBusyVector); end
    endtask

    task automatic test_mid_reset;
        do_reset();
        alloc(3, 4'd0, 1, 4'd0, 1);
        tick();
        allocRequests = '0;
        reset = 1;
        tick();
        reset = 0;
        checks++; if (ALUBusyVector !== 6'b0) begin errors++; $display("FAIL t8_busy got %b exp 000000", ALUBusyVector); end
        checks++; if (issueGrant !== 6'b0) begin errors++; $display("FAIL t8_grant got %b exp 000000", issueGrant); end
    endtask

    task automatic test_random;
        ment_t      m;
        logic [5:0] eb, eg;
        logic       ev;
        int         g;
        int         fr[$];
        do_reset();
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            eb = '0; eg = '0; g = -1;
            foreach (mq[k]) begin
                eb[mq[k].idx] = 1'b1;
                if (g < 0 && mq[k].r1 && mq[k].r2) g = k;
            end
            ev = (g >= 0);
            if (ev) eg[mq[g].idx] = 1'b1;
            checks++; if (ALUBusyVector !== eb) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, ALUBusyVector, eb); end
            checks++; if (issueValid !== ev) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, issueValid, ev); end
            checks++; if (issueGrant !== eg) begin errors++; $display("FAIL rnd_grant cyc %0d got %b exp %b", c, issueGrant, eg); end
            idle();
            issueReady = 1'($urandom_range(0, 1));
            cdbValid   = ($urandom_range(0, 2) == 0);
            cdbTag     = 4'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 199) == 0);
            fr.delete();
            for (int i = 0; i < 6; i++) if (!eb[i]) fr.push_back(i);
            if (fr.size() > 0 && $urandom_range(0, 1) == 1) begin
                m.idx     = fr[$urandom_range(0, fr.size() - 1)];
                m.t1      = 4'($urandom_range(0, 7));
                m.t2      = 4'($urandom_range(0, 7));
                src1Tag   = m.t1;
                src2Tag   = m.t2;
                src1Ready = ($urandom_range(0, 2) == 0);
                src2Ready = ($urandom_range(0, 2) == 0);
                m.r1      = src1Ready | (cdbValid && cdbTag == m.t1);
                m.r2      = src2Ready | (cdbValid && cdbTag == m.t2);
                allocRequests = 6'(1 << m.idx);
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (ev && issueReady) mq.delete(g);
                foreach (mq[k]) begin
                    if (cdbValid && mq[k].t1 == cdbTag) mq[k].r1 = 1'b1;
                    if (cdbValid && mq[k].t2 == cdbTag) mq[k].r2 = 1'b1;
                end
                if (allocRequests != 6'b0) mq.push_back(m);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_wakeup();
        test_age_order();
        test_bypass();
        test_back_to_back();
        test_full_flush();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
